// File: rtl/phankenh_12tdm.sv
// phankenh_12tdm: twelve-channel time-division demultiplexer.
// Serial bits arrive one per enabled cycle. They are steered into a
// 12-bit shadow register by a slot counter that a frame-sync pulse
// aligns, and each complete frame is copied to the o0..o11 outputs.
//
// Optional feature, selected by macro PHANKENH_SYNC_CHECK_EN:
// a sync seen in RUN at a non-zero slot raises sync_err, drops the
// partial frame, and realigns the counter to that strobe.
// Without the macro, sync is ignored in RUN and sync_err stays 0.
//
// Handshake: there is no back-pressure. en is a qualifier only.
// din and sync are consumed on every rising clk edge where en=1,
// and all state holds on edges where en=0.
module phankenh_12tdm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       din,
    input  logic       sync,
    output logic       o0,
    output logic       o1,
    output logic       o2,
    output logic       o3,
    output logic       o4,
    output logic       o5,
    output logic       o6,
    output logic       o7,
    output logic       o8,
    output logic       o9,
    output logic       o10,
    output logic       o11,
    output logic [3:0] slot,
    output logic       locked,
    output logic       frame_valid,
    output logic       sync_err
);

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] LAST_SLOT = 4'd11;

    state_t      state_q,  state_d;
    logic [3:0]  slot_q,   slot_d;
    logic [11:0] shadow_q, shadow_d;
    logic [11:0] out_q,    out_d;
    logic        fv_q,     fv_d;
    logic        serr_q,   serr_d;

    // Next-state logic: hunt for sync, then count slots and publish whole frames.
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        shadow_d = shadow_q;
        out_d    = out_q;
        fv_d     = 1'b0;
        serr_d   = 1'b0;

        if (slot_q > LAST_SLOT) begin
            // Unreachable counter value: recover by dropping lock.
            slot_d  = 4'd0;
            state_d = HUNT;
        end else if (en) begin
            if (state_q == HUNT) begin
                if (sync) begin
                    shadow_d[0] = din;
                    slot_d      = 4'd1;
                    state_d     = RUN;
                end
            end else begin
`ifdef PHANKENH_SYNC_CHECK_EN
                if (sync && (slot_q != 4'd0)) begin
                    // Misaligned frame: drop the partial frame and restart at slot 0.
                    serr_d      = 1'b1;
                    shadow_d[0] = din;
                    slot_d      = 4'd1;
                end else
`endif
                begin
                    shadow_d[slot_q] = din;
                    if (slot_q == LAST_SLOT) begin
                        // The last bit bypasses the shadow, so the output copy
                        // happens on the same edge that samples it.
                        slot_d = 4'd0;
                        out_d  = {din, shadow_q[10:0]};
                        fv_d   = 1'b1;
                    end else begin
                        slot_d = slot_q + 4'd1;
                    end
                end
            end
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HUNT;
            slot_q   <= 4'd0;
            shadow_q <= 12'd0;
            out_q    <= 12'd0;
            fv_q     <= 1'b0;
            serr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            shadow_q <= shadow_d;
            out_q    <= out_d;
            fv_q     <= fv_d;
            serr_q   <= serr_d;
        end
    end

    assign {o11, o10, o9, o8, o7, o6, o5, o4, o3, o2, o1, o0} = out_q;
    assign slot        = slot_q;
    assign locked      = (state_q == RUN);
    assign frame_valid = fv_q;
    assign sync_err    = serr_q;

endmodule

// File: doc/phankenh_12tdm.md
# phankenh_12tdm

Twelve-channel time-division demultiplexer: the receive end of the 12-input selector link. It takes one serial bit per enabled cycle from the shared line, steers it to channel slot 0..11 using an internal slot counter aligned by a frame-sync pulse, and presents all twelve channels together as registered outputs once per frame. It sits at the far end of the 4-bit-select multiplexer path, where the transmitter drives slot k onto the line when its select equals k.

## Interface
- No parameters. Channel count is fixed at 12 and the slot width is fixed at 4 bits.
- `clk`  in  1  single clock, rising-edge active
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  slot strobe; `din` and `sync` are sampled only when `en`=1
- `din`  in  1  serial line, carrying the bit for the current slot
- `sync`  in  1  frame marker, asserted together with the slot-0 bit
- `o0`..`o11`  out  1 each  registered channel outputs, updated once per complete frame
- `slot`  out  4  index of the next slot to be captured (0..11)
- `locked`  out  1  high while the FSM is in RUN
- `frame_valid`  out  1  one-cycle pulse when `o0`..`o11` take a new frame
- `sync_err`  out  1  one-cycle pulse on a misplaced sync (only with the macro; see Configuration)

## Operation
- The FSM has two states, HUNT and RUN. Reset enters HUNT.
- In HUNT:
  - `slot`=0 and `locked`=0.
  - `din` is ignored unless `en`&`sync`=1.
  - On `en`&`sync`: capture `din` into shadow[0], set `slot` to 1, go to RUN.
- In RUN, each `en`=1 cycle:
  - Capture `din` into shadow[`slot`].
  - If `slot`<11, increment `slot`.
  - If `slot`=11, wrap `slot` to 0. Copy shadow[0..10] plus the current `din` into `o0`..`o11`, and pulse `frame_valid`.
- When `en`=0, nothing changes: the state, `slot`, shadow and outputs all hold. Gaps of any length are allowed between strobes.
- The shadow register is a 12-bit double buffer. `o0`..`o11` never show a partially received frame.
- `sync` at `slot`=0 in RUN is the expected case. It is a normal capture with no error.
- Slot values 12..15 are unreachable. If one is ever reached, `slot` is forced to 0 and the FSM goes to HUNT.
- Reset values: `o0`..`o11`=0, shadow=0, `slot`=0, `locked`=0, `frame_valid`=0, `sync_err`=0, state HUNT.

## Timing
- Sampling happens on the rising `clk` edge where `en`=1.
- Latency is one clock. `o0`..`o11` and `frame_valid` change on the edge that samples slot 11 and are visible in the following cycle.
- `frame_valid` is high for exactly one `clk` cycle per frame, even if `en` stays high.
- `locked` rises one clock after the sync-qualified strobe has been sampled.
- Reset asserted mid-frame clears everything immediately, independent of the clock. The partial frame is lost and no `frame_valid` pulse is produced.
- After `rst_n` deasserts, the block stays in HUNT until the next `en`&`sync`.

## Configuration
- Macro: `PHANKENH_SYNC_CHECK_EN`.
- When defined, a `sync`&`en` sample in RUN with `slot`≠0 has these effects:
  - Pulse `sync_err` for one cycle.
  - Discard the partial frame: `o0`..`o11` are unchanged and there is no `frame_valid`.
  - Realign: capture `din` into shadow[0], set `slot` to 1, and stay in RUN.
- When not defined:
  - `sync` is ignored in RUN, and counting continues free-running.
  - `sync_err` is tied to 0.

## Test plan
- Reset then frame: assert `rst_n`=0 mid-stream. Expect all outputs 0 and `locked`=0. Release reset, then send sync plus 12 continuous strobes carrying 0xA5C with bit0 first. Expect one `frame_valid` pulse, `o11..o0`=0xA5C, and `slot` back at 0.
- Strobe gaps: the same frame with `en` low for 3 cycles between each slot. Expect an identical result, with `o*` unchanged until the slot-11 edge.
- No sync: 24 strobes in HUNT with `sync`=0. Expect `locked`=0, no `frame_valid`, and `o*`=0.
- Back-to-back frames: 0xFFF followed by 0x001 with sync at each slot 0. Expect two `frame_valid` pulses 12 strobes apart and final `o0`=1, `o1`..`o11`=0.
- Misplaced sync (macro on): sync at `slot`=5. Expect a `sync_err` pulse, `slot` becoming 1, `o*` holding the previous frame, and the next 11 strobes completing a valid frame. With the macro off, expect `sync_err`=0 and the frame to complete at the original alignment.
- Reset mid-frame: drop `rst_n` after 7 slots. Expect `o*`=0, state HUNT, and no `frame_valid` pulse.
